// File: rtl/scaler_bank_v3.sv
// Gated rising-edge scaler bank with snapshot readout on the register clock.
// Optional build macro SCALER_SATURATE_EN: live counters saturate instead of wrapping.
module scaler_bank_v3 #(
    parameter int NUM_CH        = 17,
    parameter int CNT_WIDTH     = 16,
    parameter int ADDR_WIDTH    = 6,
    parameter int GATE_MODE     = 0,
    parameter int PERIOD_CYCLES = 33000000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_CH-1:0]     scal_i,
    input  logic                  refpulse_i,
    input  logic [ADDR_WIDTH-1:0] scal_addr_i,
    input  logic                  scal_rd_i,
    output logic [CNT_WIDTH-1:0]  scal_dat_o,
    output logic                  scal_valid_o,
    output logic                  update_o,
    output logic [15:0]           refpulse_cnt_o
);

    localparam int TW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(PERIOD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

    logic [NUM_CH-1:0]    scal_q;
    logic [NUM_CH-1:0]    ev;
    logic                 ref_q;
    logic                 ref_rise;
    logic                 tmr_end;
    logic                 gate_end;
    logic [TW-1:0]        tmr;
    logic [CNT_WIDTH-1:0] cnt     [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_nxt [NUM_CH];
    logic [CNT_WIDTH-1:0] snap    [NUM_CH];
    logic [CNT_WIDTH-1:0] rd_data;

    assign ev       = scal_i & ~scal_q;
    assign ref_rise = refpulse_i & ~ref_q;
    assign tmr_end  = (tmr == TMR_LAST);
    assign gate_end = (GATE_MODE != 0) ? tmr_end : ref_rise;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scal_q <= '0;
            ref_q  <= 1'b0;
            tmr    <= '0;
        end else begin
            scal_q <= scal_i;
            ref_q  <= refpulse_i;
            tmr    <= tmr_end ? '0 : tmr + 1'b1;
        end
    end

    // Next live value includes this cycle's edge so a gate-end snapshot captures it.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
`ifdef SCALER_SATURATE_EN
            cnt_nxt[n] = (ev[n] && cnt[n] != ALL_ONES) ? cnt[n] + 1'b1 : cnt[n];
`else
            cnt_nxt[n] = cnt[n] + CNT_WIDTH'(ev[n]);
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_CH; n++) begin
                cnt[n]  <= '0;
                snap[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                cnt[n] <= gate_end ? '0 : cnt_nxt[n];
                if (gate_end) snap[n] <= cnt_nxt[n];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (scal_addr_i == ADDR_WIDTH'(n)) rd_data = snap[n];
        end
        if (scal_addr_i == ADDR_WIDTH'(NUM_CH)) rd_data = CNT_WIDTH'(refpulse_cnt_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scal_dat_o     <= '0;
            scal_valid_o   <= 1'b0;
            update_o       <= 1'b0;
            refpulse_cnt_o <= '0;
        end else begin
            scal_valid_o <= scal_rd_i;
            update_o     <= gate_end;
            if (scal_rd_i) scal_dat_o <= rd_data;
            if (gate_end) refpulse_cnt_o <= refpulse_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_scaler_bank_v3.sv
// Bench for scaler_bank_v3: a refpulse-gated 8-bit bank plus a timer-gated bank,
// both checked every cycle against integer count models.
module tb_scaler_bank_v3;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] scal;
    logic        ref_p;
    logic        rd;
    logic [5:0]  addr;
    logic [7:0]  dat;
    logic        valid;
    logic        upd;
    logic [15:0] rcnt;
    logic        rd_b;
    logic [5:0]  addr_b;
    logic [15:0] dat_b;
    logic        valid_b;
    logic        upd_b;
    logic [15:0] rcnt_b;

    int compared   = 0;
    int mismatched = 0;

    int live [17];
    int snap [17];
    bit m_prev [17];
    bit m_ref;
    int m_rcnt;
    int exp_dat;
    bit exp_valid;
    bit exp_upd;
    int b_e;

    scaler_bank_v3 #(
        .NUM_CH(17), .CNT_WIDTH(8), .ADDR_WIDTH(6),
        .GATE_MODE(0), .PERIOD_CYCLES(100)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .scal_i(scal), .refpulse_i(ref_p),
        .scal_addr_i(addr), .scal_rd_i(rd), .scal_dat_o(dat),
        .scal_valid_o(valid), .update_o(upd), .refpulse_cnt_o(rcnt)
    );

    scaler_bank_v3 #(
        .NUM_CH(17), .CNT_WIDTH(16), .ADDR_WIDTH(6),
        .GATE_MODE(1), .PERIOD_CYCLES(100)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .scal_i(scal), .refpulse_i(ref_p),
        .scal_addr_i(addr_b), .scal_rd_i(rd_b), .scal_dat_o(dat_b),
        .scal_valid_o(valid_b), .update_o(upd_b), .refpulse_cnt_o(rcnt_b)
    );

    always #5 clk = ~clk;

    function automatic int reduce(input int v);
`ifdef SCALER_SATURATE_EN
        return (v > 255) ? 255 : v;
`else
        return v % 256;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 17; c++) begin
            live[c]   = 0;
            snap[c]   = 0;
            m_prev[c] = 1'b0;
        end
        m_ref     = 1'b0;
        m_rcnt    = 0;
        exp_dat   = 0;
        exp_valid = 1'b0;
        exp_upd   = 1'b0;
        b_e       = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_dat", dat, 0);
        chk("rst_valid", valid, 0);
        chk("rst_upd", upd, 0);
        chk("rst_rcnt", rcnt, 0);
        chk("rst_b_dat", dat_b, 0);
        chk("rst_b_upd", upd_b, 0);
        chk("rst_b_rcnt", rcnt_b, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cyc(input logic [16:0] s, input logic r, input logic rdv, input logic [5:0] a);
        bit ge;
        scal  = s;
        ref_p = r;
        rd    = rdv;
        addr  = a;
        ge = r && !m_ref;
        exp_valid = rdv;
        if (rdv) begin
            if (a < 17) exp_dat = snap[a];
            else if (a == 17) exp_dat = m_rcnt % 256;
            else exp_dat = 0;
        end
        for (int c = 0; c < 17; c++) begin
            if (s[c] && !m_prev[c]) live[c]++;
            m_prev[c] = s[c];
        end
        if (ge) begin
            for (int c = 0; c < 17; c++) begin
                snap[c] = reduce(live[c]);
                live[c] = 0;
            end
            m_rcnt = (m_rcnt + 1) % 65536;
        end
        exp_upd = ge;
        m_ref   = r;
        @(posedge clk);
        #1;
        chk("valid", valid, exp_valid);
        chk("dat", dat, exp_dat);
        chk("update", upd, exp_upd);
        chk("refcnt", rcnt, m_rcnt);
        chk("b_update", upd_b, (b_e % 100 == 99));
        chk("b_refcnt", rcnt_b, (b_e + 1) / 100);
        chk("b_valid", valid_b, 0);
        b_e++;
    endtask

    initial begin
        scal   = '0;
        ref_p  = 1'b0;
        rd     = 1'b0;
        addr   = '0;
        rd_b   = 1'b0;
        addr_b = '0;
        model_reset();
        do_reset();

        // 10 edges on ch3, then a refpulse gate end
        for (int i = 0; i < 10; i++) begin
            cyc(17'h8, 0, 0, 0);
            cyc(17'h0, 0, 0, 0);
        end
        cyc(17'h0, 1, 0, 0);
        chk("t2_upd", upd, 1);
        cyc(17'h0, 0, 1, 3);
        chk("t2_ch3", dat, 10);
        cyc(17'h0, 0, 1, 0);
        chk("t2_ch0", dat, 0);
        cyc(17'h0, 0, 1, 17);
        chk("t2_refcnt", dat, 1);

        // ch1: gate of 2 edges, then 3 edges with the last coincident with gate end
        for (int i = 0; i < 2; i++) begin
            cyc(17'h2, 0, 0, 0);
            cyc(17'h0, 0, 0, 0);
        end
        cyc(17'h0, 1, 0, 0);
        cyc(17'h0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(17'h2, 0, 0, 0);
            cyc(17'h0, 0, 0, 0);
        end
        cyc(17'h2, 1, 1, 1);
        chk("t3_old", dat, 2);
        cyc(17'h0, 0, 1, 1);
        chk("t3_new", dat, 3);

        // 300 edges on ch5 in one gate
        for (int i = 0; i < 300; i++) begin
            cyc(17'h20, 0, 0, 0);
            cyc(17'h0, 0, 0, 0);
        end
        cyc(17'h0, 1, 0, 0);
        cyc(17'h0, 0, 1, 5);
`ifdef SCALER_SATURATE_EN
        chk("t4_ovf", dat, 255);
`else
        chk("t4_ovf", dat, 44);
`endif

        // reset mid-gate, ch0 high across release
        for (int i = 0; i < 5; i++) begin
            cyc(17'h1, 0, 0, 0);
            cyc(17'h0, 0, 0, 0);
        end
        cyc(17'h1, 0, 0, 0);
        do_reset();
        cyc(17'h1, 0, 0, 0);
        cyc(17'h0, 0, 0, 0);
        cyc(17'h1, 0, 0, 0);
        cyc(17'h0, 0, 0, 0);
        cyc(17'h1, 0, 0, 0);
        cyc(17'h0, 1, 0, 0);
        cyc(17'h0, 0, 1, 0);
        chk("t1_ch0", dat, 3);
        cyc(17'h0, 0, 1, 17);
        chk("t1_refcnt", dat, 1);

        // back-to-back sweep of all addresses
        for (int a = 0; a < 64; a++) cyc(17'h0, 0, 1, 6'(a));
        cyc(17'h0, 0, 0, 0);
        chk("t6_idle_valid", valid, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(17'($urandom), ($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        end
        cyc(17'h0, 0, 0, 0);
        cyc(17'h0, 1, 0, 0);
        for (int a = 0; a < 64; a++) cyc(17'h0, 0, 1, 6'(a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
